// File: rtl/mm_pkg.sv
// Shared types for the mm_seq matrix-multiply sequencer: FSM state encoding,
// registered output bundle and the default drain length.
package mm_pkg;

  localparam int unsigned DIM_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    DRAIN,
    READ,
    DONE
  } mm_state_t;

  typedef struct packed {
    logic clr;
    logic busy;
    logic done;
    logic ab_req;
    logic c_rd;
    logic drain_en;
  } mm_out_t;

  // Skew-buffer depth (dim-1) plus array propagation (dim).
  function automatic int unsigned drain_cycles(input int unsigned dim);
    return 2 * dim - 1;
  endfunction

  function automatic mm_out_t mm_decode(input mm_state_t s);
    mm_out_t o;
    o          = '0;
    o.busy     = (s != IDLE);
    o.clr      = (s == CLEAR);
    o.ab_req   = (s == LOAD);
    o.drain_en = (s == DRAIN);
    o.c_rd     = (s == READ);
    o.done     = (s == DONE);
    return o;
  endfunction

endpackage

// File: rtl/mm_seq_cnt.sv
// Loadable up-counter with an exact-equality terminal-count flag; used for the
// row, drain and result-read counters of mm_seq.
module mm_seq_cnt #(
  parameter int unsigned W    = 4,
  parameter int unsigned TERM = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= q + 1'b1;
    end
  end

  assign tc = (q == W'(TERM));

endmodule

// File: rtl/mm_seq.sv
// Sequencer for one DIM x DIM systolic matrix multiply: clear, load rows, drain, read C.
// Optional cycle counter output perf_cycles when MM_SEQ_PERF_EN is defined.
module mm_seq
  import mm_pkg::*;
#(
  parameter int unsigned DIM       = DIM_DEF,
  parameter int unsigned DRAIN_CYC = drain_cycles(DIM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [$clog2(DIM)-1:0] ab_row,
  output logic                   ab_req,
  input  logic                   ab_valid,
  output logic                   en,
  output logic                   clr,
  output logic [$clog2(DIM)-1:0] c_row,
  output logic                   c_rd,
  output logic                   busy,
  output logic                   done
`ifdef MM_SEQ_PERF_EN
  ,
  output logic [15:0]            perf_cycles
`endif
);

  localparam int unsigned RW = $clog2(DIM);
  localparam int unsigned DW = $clog2(DRAIN_CYC + 1);

  mm_state_t         state, nx;
  mm_out_t           outs;
  logic [RW-1:0]     row_q, rd_q;
  logic [DW-1:0]     drain_q;
  logic              row_tc, drain_tc, rd_tc;
  logic              row_take;
  logic              in_drain, in_read;

  assign row_take = outs.ab_req & ab_valid;
  assign in_drain = (state == DRAIN);
  assign in_read  = (state == READ);

  always_comb begin
    nx = state;
    unique case (state)
      IDLE:    if (start) nx = CLEAR;
      CLEAR:   nx = LOAD;
      LOAD:    if (row_take && row_tc) nx = DRAIN;
      DRAIN:   if (drain_tc) nx = READ;
      READ:    if (rd_tc) nx = DONE;
      DONE:    nx = IDLE;
      default: nx = IDLE;
    endcase
  end

  // Outputs are registered by decoding the next state alongside the state flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      outs  <= '0;
    end else begin
      state <= nx;
      outs  <= mm_decode(nx);
    end
  end

  // Counters reload to 0 at their terminal value so indices read 0 outside their phase.
  mm_seq_cnt #(.W(RW), .TERM(DIM - 1)) u_row (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((state == CLEAR) || (row_take && row_tc)),
    .load_val ('0),
    .inc      (row_take),
    .q        (row_q),
    .tc       (row_tc)
  );

  mm_seq_cnt #(.W(DW), .TERM(DRAIN_CYC - 1)) u_drain (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (in_drain && drain_tc),
    .load_val ('0),
    .inc      (in_drain),
    .q        (drain_q),
    .tc       (drain_tc)
  );

  mm_seq_cnt #(.W(RW), .TERM(DIM - 1)) u_read (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (in_read && rd_tc),
    .load_val ('0),
    .inc      (in_read),
    .q        (rd_q),
    .tc       (rd_tc)
  );

  assign ab_row = row_q;
  assign c_row  = rd_q;
  assign ab_req = outs.ab_req;
  assign en     = row_take | outs.drain_en;
  assign clr    = outs.clr;
  assign c_rd   = outs.c_rd;
  assign busy   = outs.busy;
  assign done   = outs.done;

`ifdef MM_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles <= '0;
    end else if (outs.busy && perf_cycles != '1) begin
      perf_cycles <= perf_cycles + 1'b1;
    end
  end
`endif

endmodule
